// File: rtl/tx_stream_mux_if.sv
// Port bundle for tx_stream_mux: button, enable mask, per-channel byte streams and the
// selected MAC-side stream with routing status. The mux itself uses the slave modport.
interface tx_stream_mux_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic                     button;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH*DATA_W-1:0] mac_tx_data_in;
  logic [NUM_CH-1:0]        mac_tx_data_valid_in;
  logic [DATA_W-1:0]        mac_tx_data;
  logic                     mac_tx_data_valid;
  logic [CH_W-1:0]          channel_open;
  logic                     pending_switch;

  modport master (
    output button, ch_enable, mac_tx_data_in, mac_tx_data_valid_in,
    input  mac_tx_data, mac_tx_data_valid, channel_open, pending_switch
  );

  modport slave (
    input  button, ch_enable, mac_tx_data_in, mac_tx_data_valid_in,
    output mac_tx_data, mac_tx_data_valid, channel_open, pending_switch
  );
endinterface

// File: rtl/tx_stream_mux.sv
// Frame-safe N:1 transmit stream selector; one register of latency, channel steps on a debounced press.
// No backpressure: frames on unrouted channels or starting inside the post-frame gap are dropped.
module tx_stream_mux #(
  parameter int NUM_CH       = 3,
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 2500000,
  parameter int GAP_CYC      = 12
) (
  input  logic          rgmii_clk,
  input  logic          rst_n,
  tx_stream_mux_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_GAP} state_t;

  logic              r_btn_meta;
  logic              r_btn_sync;
  logic              r_btn_stable;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_adv;
  logic [CH_W-1:0]   r_req_ch;
  logic [CH_W-1:0]   r_ch_open;
  logic [NUM_CH-1:0] r_vld_d;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_vld;
  state_t            r_state;

  state_t            w_state_nxt;
  logic [CH_W-1:0]   w_req_nxt;
  logic [CH_W-1:0]   w_idx;
  logic              w_found;
  logic [DATA_W-1:0] w_act_dat;
  logic              w_act_vld;
  logic              w_act_prev;
  logic              w_act_en;
  logic              w_act_rise;
  logic              w_switch;
  logic              w_start;
  logic [DATA_W-1:0] w_out_dat;
  logic              w_out_vld;

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
    end else begin
      r_btn_meta <= bus.button;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Level must differ from the accepted one for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_stable <= 1'b1;
      r_db_cnt     <= '0;
      r_adv        <= 1'b0;
    end else begin
      r_adv <= 1'b0;
      if (r_btn_sync != r_btn_stable) begin
        if (r_db_cnt == DB_LAST) begin
          r_btn_stable <= r_btn_sync;
          r_db_cnt     <= '0;
          r_adv        <= ~r_btn_sync;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_req_nxt = r_req_ch;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_req_ch) + k) % NUM_CH);
      if (!w_found && bus.ch_enable[w_idx]) begin
        w_req_nxt = w_idx;
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin
    w_act_dat  = '0;
    w_act_vld  = 1'b0;
    w_act_prev = 1'b0;
    w_act_en   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch_open == CH_W'(k)) begin
        w_act_dat  = bus.mac_tx_data_in[k*DATA_W +: DATA_W];
        w_act_vld  = bus.mac_tx_data_valid_in[k];
        w_act_prev = r_vld_d[k];
        w_act_en   = bus.ch_enable[k];
      end
    end
  end

  assign w_act_rise = w_act_vld & ~w_act_prev;
  assign w_switch   = (r_req_ch != r_ch_open);
  // A channel switch takes priority over a frame start in the same IDLE cycle.
  assign w_start    = ~w_switch & w_act_en & w_act_rise;

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_PASS;
      S_PASS: if (!w_act_vld) w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_vld = 1'b0;
    w_out_dat = '0;
    case (r_state)
      S_IDLE: begin
        w_out_vld = w_start;
        w_out_dat = w_start ? w_act_dat : '0;
      end
      S_PASS: begin
        w_out_vld = w_act_vld;
        w_out_dat = w_act_vld ? w_act_dat : '0;
      end
      default: begin
        w_out_vld = 1'b0;
        w_out_dat = '0;
      end
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_dat <= '0;
      r_out_vld <= 1'b0;
      r_vld_d   <= '0;
      r_req_ch  <= '0;
      r_ch_open <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_out_dat <= w_out_dat;
      r_out_vld <= w_out_vld;
      r_vld_d   <= bus.mac_tx_data_valid_in;
      if (r_adv) begin
        r_req_ch <= w_req_nxt;
      end
      if (r_state == S_IDLE && w_switch) begin
        r_ch_open <= r_req_ch;
      end
      if (r_state == S_PASS && !w_act_vld) begin
        r_gap_cnt <= GAP_LOAD;
      end else if (r_state == S_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign bus.mac_tx_data       = r_out_dat;
  assign bus.mac_tx_data_valid = r_out_vld;
  assign bus.channel_open      = r_ch_open;
  assign bus.pending_switch    = w_switch;
endmodule

// File: tb/tb_tx_stream_mux.sv
// Directed bench for tx_stream_mux: table of single-frame vectors plus hand-written
// sequences for debounce, deferred switching, enable masks, gap boundary and async reset.
module tb_tx_stream_mux;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_stream_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  tx_stream_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE_CYC(4), .GAP_CYC(12)
  ) dut (
    .rgmii_clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       exp_vld;
    logic [7:0] exp_dat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [7:0] d);
    bus.mac_tx_data_valid_in[ch] = v;
    bus.mac_tx_data_in[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic press();
    bus.button = 1'b0;
    repeat (10) tick();
    bus.button = 1'b1;
    repeat (10) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Frame of 8 beats, `gap` idle cycles, second frame of 8 beats on ch0.
  task automatic two_frames(input int gap, input logic ok2, input logic [7:0] base);
    logic in1, in2, ev;
    for (int t = 0; t < 32 + gap; t++) begin
      in1 = (t < 8);
      in2 = (t >= 8 + gap) && (t < 16 + gap);
      set_ch(0, in1 | in2, base + 8'(t));
      tick();
      ev = in1 | (ok2 & in2);
      chk("b2b_vld", 32'(bus.mac_tx_data_valid), 32'(ev));
      chk("b2b_dat", 32'(bus.mac_tx_data), ev ? 32'(base + 8'(t)) : 32'd0);
    end
    set_ch(0, 1'b0, 8'h00);
  endtask

  vec_t vecs[68];

  initial begin
    logic ev, c1v;
    logic [7:0] ed;

    rst_n = 1'b0;
    bus.button = 1'b1;
    bus.ch_enable = 3'b111;
    bus.mac_tx_data_in = '0;
    bus.mac_tx_data_valid_in = '0;

    for (int i = 0; i < 68; i++) begin
      if (i >= 1 && i <= 64) vecs[i] = '{1'b1, 8'(i - 1), 1'b1, 8'(i - 1)};
      else                   vecs[i] = '{1'b0, 8'h00, 1'b0, 8'h00};
    end

    #2;
    chk("rst_dat", 32'(bus.mac_tx_data), 32'd0);
    chk("rst_vld", 32'(bus.mac_tx_data_valid), 32'd0);
    chk("rst_open", 32'(bus.channel_open), 32'd0);
    chk("rst_pend", 32'(bus.pending_switch), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 64-byte frame on ch0
    for (int i = 0; i < 68; i++) begin
      set_ch(0, vecs[i].vld, vecs[i].dat);
      tick();
      chk("frame_vld", 32'(bus.mac_tx_data_valid), 32'(vecs[i].exp_vld));
      chk("frame_dat", 32'(bus.mac_tx_data), 32'(vecs[i].exp_dat));
    end
    chk("frame_open", 32'(bus.channel_open), 32'd0);

    // Short glitch must not advance
    bus.button = 1'b0;
    repeat (2) tick();
    bus.button = 1'b1;
    repeat (12) tick();
    chk("glitch_pend", 32'(bus.pending_switch), 32'd0);
    chk("glitch_open", 32'(bus.channel_open), 32'd0);

    bus.button = 1'b0;
    repeat (10) tick();
    chk("press_open", 32'(bus.channel_open), 32'd1);
    chk("press_pend", 32'(bus.pending_switch), 32'd0);
    bus.button = 1'b1;
    repeat (10) tick();
    chk("release_open", 32'(bus.channel_open), 32'd1);
    press();
    chk("seq_open2", 32'(bus.channel_open), 32'd2);
    press();
    chk("seq_wrap0", 32'(bus.channel_open), 32'd0);
    repeat (5) tick();

    // Gap boundary on ch0
    two_frames(1, 1'b0, 8'h10);
    two_frames(13, 1'b1, 8'h40);
    two_frames(12, 1'b0, 8'h80);

    // Press mid-frame; ch1 frame in progress at switch time is suppressed
    for (int t = 0; t < 111; t++) begin
      set_ch(0, t < 60, 8'(t));
      c1v = (t >= 40 && t < 90) || (t >= 95 && t < 105);
      set_ch(1, c1v, 8'(t) + 8'h80);
      bus.button = !(t >= 20 && t < 30);
      tick();
      ev = (t < 60) || (t >= 95 && t < 105);
      ed = (t < 60) ? 8'(t) : (ev ? 8'(t) + 8'h80 : 8'h00);
      chk("defer_vld", 32'(bus.mac_tx_data_valid), 32'(ev));
      chk("defer_dat", 32'(bus.mac_tx_data), 32'(ed));
      if (t == 50) begin
        chk("defer_pend", 32'(bus.pending_switch), 32'd1);
        chk("defer_open_hold", 32'(bus.channel_open), 32'd0);
      end
      if (t == 80) begin
        chk("defer_open1", 32'(bus.channel_open), 32'd1);
        chk("defer_pend_clr", 32'(bus.pending_switch), 32'd0);
      end
    end
    set_ch(0, 1'b0, 8'h00);
    set_ch(1, 1'b0, 8'h00);
    bus.button = 1'b1;

    // Enable mask stepping
    do_reset();
    chk("mask_rst_open", 32'(bus.channel_open), 32'd0);
    bus.ch_enable = 3'b101;
    press();
    chk("mask_a", 32'(bus.channel_open), 32'd2);
    press();
    chk("mask_b", 32'(bus.channel_open), 32'd0);
    press();
    chk("mask_c", 32'(bus.channel_open), 32'd2);
    press();
    chk("mask_d", 32'(bus.channel_open), 32'd0);
    bus.ch_enable = 3'b001;
    press();
    chk("only0_a", 32'(bus.channel_open), 32'd0);
    chk("only0_pend", 32'(bus.pending_switch), 32'd0);
    press();
    chk("only0_b", 32'(bus.channel_open), 32'd0);
    bus.ch_enable = 3'b111;
    repeat (3) tick();

    // Async reset in the middle of a frame
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 1'b1, 8'h11 + 8'(k));
      tick();
      chk("pre_rst_vld", 32'(bus.mac_tx_data_valid), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(bus.mac_tx_data_valid), 32'd0);
    chk("async_dat", 32'(bus.mac_tx_data), 32'd0);
    set_ch(0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_idle", 32'(bus.mac_tx_data_valid), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 1'b1, 8'hC0 + 8'(k));
      tick();
      chk("post_rst_vld", 32'(bus.mac_tx_data_valid), 32'd1);
      chk("post_rst_dat", 32'(bus.mac_tx_data), 32'(8'hC0 + 8'(k)));
    end
    set_ch(0, 1'b0, 8'h00);
    tick();
    chk("post_rst_end", 32'(bus.mac_tx_data_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_stream_mux.md
# tx_stream_mux

Parametrised N-channel transmit-stream selector sitting in front of the Ethernet MAC in the `rgmii_clk` domain. It forwards one of `NUM_CH` byte streams to the MAC and steps to the next enabled channel on a debounced button press. Channel changes take effect only between frames, so the MAC never sees a truncated or spliced frame. A minimum inter-frame gap is enforced after every forwarded frame.

## Interface
- `NUM_CH`, 3, number of input streams (2..16)
- `DATA_W`, 8, data width per stream
- `DEBOUNCE_CYC`, 2500000, consecutive stable cycles required to accept a button level (20 ms at 125 MHz)
- `GAP_CYC`, 12, idle cycles forced after each frame (0 allowed)
- localparam `CH_W` = max(1, $clog2(`NUM_CH`))

Ports:
- `rgmii_clk` in 1: sole clock
- `rst_n` in 1: asynchronous, active-low reset
- `button` in 1: raw, asynchronous, active-low push button
- `ch_enable` in NUM_CH: per-channel enable mask, static-ish, sampled every cycle
- `mac_tx_data_in` in NUM_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W]
- `mac_tx_data_valid_in` in NUM_CH: per-channel frame valid (high for the whole frame, contiguous)
- `mac_tx_data` out DATA_W: selected data, registered
- `mac_tx_data_valid` out 1: selected valid, registered
- `channel_open` out CH_W: channel currently routed
- `pending_switch` out 1: high while the requested channel differs from `channel_open`

## Operation
- Button path: 2-FF synchroniser, then debouncer. A counter increments while the synced level differs from the stable level and clears when they match. When it reaches `DEBOUNCE_CYC`, the stable level updates. A stable high→low transition (press) produces a 1-cycle `adv` pulse. Release produces nothing.
- Request register `req_ch`: on `adv`, it moves to the next index above `req_ch` (mod `NUM_CH`) whose `ch_enable` bit is set, searching at most NUM_CH-1 steps. If no other channel is enabled, `req_ch` is unchanged.
- `pending_switch` = (`req_ch` != `channel_open`).
- FSM states:
  - IDLE: outputs data 0 / valid 0.
    - If `req_ch` != `channel_open`: load `channel_open` <= `req_ch`, stay in IDLE one cycle.
    - Else, if the active channel is enabled and shows a valid rising edge (valid=1 now, 0 the previous cycle, tracked per channel in `vld_d`): go to PASS, forwarding that beat.
  - PASS: forward the active channel's data and valid each cycle. On the first cycle its valid=0, output valid 0 / data 0 and go to GAP, with the counter loaded to `GAP_CYC`-1. If `GAP_CYC`=0, go directly to IDLE.
  - GAP: outputs 0. Count down; at 0, go to IDLE.
- A channel whose valid is already high when it becomes active (mid-frame) is ignored until its valid falls and rises again.
- `ch_enable` deasserted mid-frame: the current frame completes; no new frame starts from that channel.
- `adv` during PASS/GAP: only `req_ch` updates; the switch applies at the next IDLE. Multiple presses accumulate (each advances `req_ch`).
- Frames on non-selected channels are discarded; no buffering.

## Timing
- Reset values: `mac_tx_data`=0, `mac_tx_data_valid`=0, `channel_open`=0, `req_ch`=0, `pending_switch`=0, FSM=IDLE, debounce stable=released (1), counters 0, `vld_d`=0.
- Reset is asynchronous: asserting `rst_n` mid-frame clears the outputs immediately, without waiting for a clock edge.
- Data latency: an input beat at edge t appears on the output after edge t+1. The first beat of a frame has the same latency.
- Press-to-`adv`: 2 sync cycles + `DEBOUNCE_CYC` cycles + 1.
- Switch cost: 1 IDLE cycle for the `channel_open` update before a new frame can be accepted.
- Minimum output spacing: the last valid beat is followed by at least `GAP_CYC`+1 invalid cycles.

## Test plan
- Sim params NUM_CH=3, DEBOUNCE_CYC=4, GAP_CYC=12, all enabled. Ch0 sends a 64-byte frame 0x00..0x3F → output identical bytes, 1-cycle delay, `channel_open`=0.
- Button pulse low for 2 cycles (glitch) → no `adv`, `req_ch` stays 0. Held low 10 cycles → exactly one `adv`, `channel_open`=1.
- Press at byte 20 of a 60-byte ch0 frame → all 60 bytes forwarded, then a 12-cycle gap. `channel_open` becomes 1 in the following IDLE. A ch1 frame already in progress at that point is suppressed entirely; the next ch1 frame passes.
- `ch_enable`=3'b101, three presses from ch0 → sequence 2, 0, 2. With `ch_enable`=3'b001, presses leave `channel_open` at 0.
- Back-to-back ch0 frames separated by 1 idle cycle → the second frame is dropped if it starts inside GAP. With spacing ≥ 13 cycles, both are forwarded.
- Assert `rst_n`=0 mid-PASS → `mac_tx_data_valid`=0 with no clock edge. After release, the outputs stay 0 until the next valid rising edge on ch0.
